// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding, debug indices and output decode.
// The debug CSR block imports the same encodings to interpret seq_state.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_MEM       = 3'd2,
        ST_CORE      = 3'd3,
        ST_LOADER    = 3'd4,
        ST_CPU       = 3'd5,
        ST_RUN       = 3'd6
    } seq_state_e;

    localparam logic [2:0] ST_IDX_MEM  = 3'd2;
    localparam logic [2:0] ST_IDX_RUN  = 3'd6;
    localparam int         LOSS_CNT_W  = 8;

    typedef struct packed {
        logic mem_rst_n;
        logic core_rst_n;
        logic loader_rst_n;
        logic cpu_rst_n;
        logic all_ready;
    } rst_out_t;

    // A reset is released in its own stage and every later one, so a single
    // state compare per output keeps the releases monotonic by construction.
    function automatic rst_out_t decode_outputs(input seq_state_e s);
        rst_out_t o;
        o.mem_rst_n    = (s >= ST_MEM)    && (s <= ST_RUN);
        o.core_rst_n   = (s >= ST_CORE)   && (s <= ST_RUN);
        o.loader_rst_n = (s >= ST_LOADER) && (s <= ST_RUN);
        o.cpu_rst_n    = (s >= ST_CPU)    && (s <= ST_RUN);
        o.all_ready    = (s == ST_RUN);
        return o;
    endfunction

    function automatic seq_state_e next_stage(input seq_state_e s);
        seq_state_e n;
        case (s)
            ST_MEM:    n = ST_CORE;
            ST_CORE:   n = ST_LOADER;
            ST_LOADER: n = ST_CPU;
            default:   n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level, synchronously reset to 0.
// Also reused by the downstream per-domain reset synchronisers.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking assignment lets every flop sample its
            // predecessor's old value, which is what makes this a shift chain.
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases the mem, core, loader and cpu resets in order once the main PLL is
// stably locked; re-sequences on lock loss or software request.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int STAGE_DELAY = 256,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_locked_async,
    input  logic                  sw_rst_req,
    output logic                  mem_rst_n,
    output logic                  core_rst_n,
    output logic                  loader_rst_n,
    output logic                  cpu_rst_n,
    output logic                  all_ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            seq_state
);

    localparam logic [CNT_W-1:0]      FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]      STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

    logic                  w_lock_s;
    seq_state_e            r_state;
    seq_state_e            w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_next_cnt;
    logic                  w_lock_loss;
    rst_out_t              r_out;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_d      (pll_locked_async),
        .o_q      (w_lock_s)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_lock_loss  = 1'b0;

        unique case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = ST_FILTER;
                    w_next_cnt   = '0;
                end
            end
            ST_FILTER: begin
                // A lock drop here is treated as a glitch, not a loss event.
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                end else if (r_cnt == FILTER_LAST) begin
                    w_next_state = ST_MEM;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_MEM, ST_CORE, ST_LOADER, ST_CPU, ST_RUN: begin
                // Lock loss outranks a simultaneous software request.
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                    w_lock_loss  = 1'b1;
                end else if (sw_rst_req) begin
                    w_next_state = ST_FILTER;
                    w_next_cnt   = '0;
                end else if (r_state != ST_RUN) begin
                    if (r_cnt == STAGE_LAST) begin
                        w_next_state = next_stage(r_state);
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are flopped from the next state so each reset line is a clean
    // register output, never a decode glitch of the state bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_WAIT_LOCK;
            r_cnt      <= '0;
            r_out      <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_out   <= decode_outputs(w_next_state);
            if (w_lock_loss && (r_loss_cnt != LOSS_MAX)) begin
                r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
            end
        end
    end

    assign mem_rst_n     = r_out.mem_rst_n;
    assign core_rst_n    = r_out.core_rst_n;
    assign loader_rst_n  = r_out.loader_rst_n;
    assign cpu_rst_n     = r_out.cpu_rst_n;
    assign all_ready     = r_out.all_ready;
    assign lock_loss_cnt = r_loss_cnt;
    assign seq_state     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timeline table, directed corner
// sequences and randomized stimulus against a threshold-based reference model.
module tb_reset_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_FILTER = 4;
    localparam int STAGE_DELAY = 8;
    localparam int CNT_W       = 8;
    localparam int T_RUN       = LOCK_FILTER + 4 * STAGE_DELAY;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_locked_async;
    logic       sw_rst_req;
    logic       mem_rst_n;
    logic       core_rst_n;
    logic       loader_rst_n;
    logic       cpu_rst_n;
    logic       all_ready;
    logic [7:0] lock_loss_cnt;
    logic [2:0] seq_state;

    reset_sequencer #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_FILTER (LOCK_FILTER),
        .STAGE_DELAY (STAGE_DELAY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .pll_locked_async (pll_locked_async),
        .sw_rst_req       (sw_rst_req),
        .mem_rst_n        (mem_rst_n),
        .core_rst_n       (core_rst_n),
        .loader_rst_n     (loader_rst_n),
        .cpu_rst_n        (cpu_rst_n),
        .all_ready        (all_ready),
        .lock_loss_cnt    (lock_loss_cnt),
        .seq_state        (seq_state)
    );

    always #25 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model: a sequence is "active" once synced lock is seen, and
    // m_t counts edges since the filter window opened; every output is a
    // threshold on m_t.
    logic [SYNC_STAGES-1:0] m_sync;
    bit                     m_active;
    int                     m_t;
    int                     m_llc;

    typedef struct {
        int         edge_no;
        logic [4:0] outs;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_outs();
        return {mem_rst_n, core_rst_n, loader_rst_n, cpu_rst_n, all_ready};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {seq_state, lock_loss_cnt, dut_outs()};
    endfunction

    function automatic logic [15:0] model_vec();
        logic [2:0] st;
        logic [4:0] o;
        int         stage;
        if (!m_active) begin
            st = 3'd0;
        end else if (m_t < LOCK_FILTER) begin
            st = 3'd1;
        end else begin
            stage = (m_t - LOCK_FILTER) / STAGE_DELAY;
            if (stage > 4) stage = 4;
            st = 3'(2 + stage);
        end
        o[4] = m_active && (m_t >= LOCK_FILTER);
        o[3] = m_active && (m_t >= LOCK_FILTER + STAGE_DELAY);
        o[2] = m_active && (m_t >= LOCK_FILTER + 2 * STAGE_DELAY);
        o[1] = m_active && (m_t >= LOCK_FILTER + 3 * STAGE_DELAY);
        o[0] = m_active && (m_t >= T_RUN);
        return {st, 8'(m_llc), o};
    endfunction

    task automatic model_step();
        bit lock_s;
        bit released;
        if (!resetn) begin
            m_active = 1'b0;
            m_t      = 0;
            m_llc    = 0;
            m_sync   = '0;
        end else begin
            lock_s   = m_sync[SYNC_STAGES-1];
            released = m_active && (m_t >= LOCK_FILTER);
            if (!m_active) begin
                if (lock_s) begin
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else if (!lock_s) begin
                if (released && m_llc < 255) m_llc++;
                m_active = 1'b0;
                m_t      = 0;
            end else if (sw_rst_req && released) begin
                m_t = 0;
            end else if (m_t < T_RUN) begin
                m_t++;
            end
            m_sync = {m_sync[SYNC_STAGES-2:0], pll_locked_async};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        edge_n++;
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    initial begin
        logic mem_seen;

        tbl[0] = '{6,  5'b00000};
        tbl[1] = '{7,  5'b10000};
        tbl[2] = '{14, 5'b10000};
        tbl[3] = '{15, 5'b11000};
        tbl[4] = '{22, 5'b11000};
        tbl[5] = '{23, 5'b11100};
        tbl[6] = '{30, 5'b11100};
        tbl[7] = '{31, 5'b11110};
        tbl[8] = '{38, 5'b11110};
        tbl[9] = '{39, 5'b11111};

        m_sync   = '0;
        m_active = 1'b0;
        m_t      = 0;
        m_llc    = 0;

        // Power-on
        resetn           = 1'b0;
        pll_locked_async = 1'b0;
        sw_rst_req       = 1'b0;
        repeat (5) tick();
        check("reset_state", 32'(dut_vec()), 32'h0);
        resetn           = 1'b1;
        pll_locked_async = 1'b1;
        edge_n           = 0;
        for (int i = 0; i < 10; i++) begin
            while (edge_n < tbl[i].edge_no) tick();
            check($sformatf("power_on_edge%0d", tbl[i].edge_no), 32'(dut_outs()), 32'(tbl[i].outs));
        end
        check("power_on_llc", 32'(lock_loss_cnt), 32'd0);
        check("power_on_state", 32'(seq_state), 32'd6);

        // Short lock glitch inside FILTER
        resetn           = 1'b0;
        pll_locked_async = 1'b0;
        repeat (2) tick();
        resetn           = 1'b1;
        pll_locked_async = 1'b1;
        repeat (3) tick();
        pll_locked_async = 1'b0;
        mem_seen = 1'b0;
        repeat (10) begin
            tick();
            mem_seen = mem_seen | mem_rst_n;
        end
        check("glitch_no_release", 32'(mem_seen), 32'd0);
        check("glitch_state", 32'(seq_state), 32'd0);
        check("glitch_llc", 32'(lock_loss_cnt), 32'd0);

        // Lock loss in LOADER
        pll_locked_async = 1'b1;
        edge_n = 0;
        while (edge_n < 26) tick();
        check("loader_reached", 32'(dut_outs()), 32'(5'b11100));
        pll_locked_async = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
        check("loss_outs_low", 32'(dut_outs()), 32'd0);
        check("loss_state", 32'(seq_state), 32'd0);
        check("loss_llc", 32'(lock_loss_cnt), 32'd1);
        pll_locked_async = 1'b1;
        edge_n = 0;
        while (edge_n < 38) tick();
        check("relock_cpu_only", 32'(dut_outs()), 32'(5'b11110));
        tick();
        check("relock_ready", 32'(dut_outs()), 32'(5'b11111));

        // Software request in RUN
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check("sw_outs_cleared", 32'(dut_outs()), 32'd0);
        check("sw_state_filter", 32'(seq_state), 32'd1);
        repeat (3) tick();
        check("sw_mem_held", 32'(dut_outs()), 32'd0);
        tick();
        check("sw_mem_release", 32'(dut_outs()), 32'(5'b10000));
        repeat (7) tick();
        check("sw_core_held", 32'(dut_outs()), 32'(5'b10000));
        tick();
        check("sw_core_release", 32'(dut_outs()), 32'(5'b11000));

        // Lock loss and sw_rst_req on the same cycle
        repeat (30) tick();
        check("pre_simul_run", 32'(dut_outs()), 32'(5'b11111));
        pll_locked_async = 1'b0;
        repeat (SYNC_STAGES) tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check("simul_state", 32'(seq_state), 32'd0);
        check("simul_llc", 32'(lock_loss_cnt), 32'd2);

        // Saturation of the loss counter
        for (int k = 0; k < 300; k++) begin
            pll_locked_async = 1'b1;
            repeat (8) tick();
            pll_locked_async = 1'b0;
            repeat (SYNC_STAGES + 1) tick();
        end
        check("llc_saturated", 32'(lock_loss_cnt), 32'd255);

        // resetn mid-CORE
        pll_locked_async = 1'b1;
        edge_n = 0;
        while (edge_n < 18) tick();
        check("core_reached", 32'(dut_outs()), 32'(5'b11000));
        resetn = 1'b0;
        tick();
        check("mid_core_reset", 32'(dut_vec()), 32'h0);
        resetn = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(79) == 0) pll_locked_async = ~pll_locked_async;
            sw_rst_req = ($urandom_range(31) == 0);
            resetn     = ($urandom_range(599) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
